arb_requester: RTL and testbench
================================

ARB_REQUESTER -- requirements
Module: arb_requester

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12: command/bus address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: data width.
REQ-003 SHALL have parameter FIFO_DEPTH_LOG2, default 2: command FIFO holds 2^N entries.
REQ-004 SHALL have parameter MAX_BURST, default 4, range 1..255: maximum transfers per grant.
REQ-005 SHALL have port clk  in  1: single clock, rising edge.
REQ-006 SHALL have port reset  in  1: asynchronous, active-low reset.
REQ-007 SHALL have ports cmd_valid in 1, cmd_ready out 1, cmd_addr in ADDR_WIDTH, cmd_wrdata in DATA_WIDTH, cmd_rdWrn in 1 (1=read): command push interface.
REQ-008 SHALL have ports rsp_valid out 1, rsp_rddata out DATA_WIDTH: read response, no backpressure.
REQ-009 SHALL have ports req out 1, ack in 1, address out ADDR_WIDTH, wrdata out DATA_WIDTH, rddata in DATA_WIDTH, rdWrn out 1: arbiter client port.
REQ-010 SHALL have ports fifo_count out FIFO_DEPTH_LOG2+1, xfer_count out 16, preempt_count out 8: status.

Function
REQ-011 Push SHALL occur on an edge with cmd_valid & cmd_ready; cmd_ready SHALL equal !full, with no same-cycle pop bypass when full.
REQ-012 address/wrdata/rdWrn SHALL present the FIFO head entry whenever the FIFO is non-empty, and hold the last value otherwise.
REQ-013 FSM states SHALL be IDLE, REQ, RELEASE; req SHALL be 1 only in REQ.
REQ-014 IDLE -> REQ on the edge after the FIFO is non-empty; the burst counter SHALL clear on entering REQ.
REQ-015 A transfer SHALL occur on each edge where state is REQ, ack=1 and the FIFO is non-empty; each transfer pops the head and increments the burst counter.
REQ-016 For a read transfer, rsp_valid SHALL be high for exactly the following cycle, with rsp_rddata equal to rddata sampled at the transfer edge; writes SHALL produce no response.
REQ-017 REQ -> RELEASE SHALL occur on the transfer edge that either empties the FIFO or brings the burst counter to MAX_BURST.
REQ-018 RELEASE SHALL last exactly one cycle (req=0), then go to IDLE.
REQ-019 If ack falls while in REQ with entries pending (preemption), the FSM SHALL stay in REQ with req=1, keep the burst count, lose no entries, and resume transfers when ack returns.
REQ-020 A push and a pop on the same edge SHALL leave fifo_count unchanged; the FIFO pointers SHALL wrap modulo 2^FIFO_DEPTH_LOG2.

Reset
REQ-021 Reset SHALL force state IDLE, FIFO empty, fifo_count 0, req 0, rsp_valid 0, rsp_rddata 0, address/wrdata/rdWrn 0, and counters 0, immediately and regardless of clk.
REQ-022 Reset mid-burst SHALL discard all queued commands and deassert req asynchronously.

Configuration
REQ-023 With ARB_REQUESTER_STATS_EN defined: xfer_count SHALL count transfers, saturating at 16'hFFFF; preempt_count SHALL count ack falling edges while state is REQ and the FIFO is non-empty, saturating at 8'hFF.
REQ-024 Without ARB_REQUESTER_STATS_EN: xfer_count and preempt_count SHALL be tied to 0, no counter logic SHALL be present, and all other behaviour SHALL be identical.

Structure
REQ-025 Package arb_pkg SHALL hold the ADDR_WIDTH/DATA_WIDTH defaults, the FSM state encoding, and the command record type {addr, wrdata, rdWrn}.
REQ-026 The command FIFO SHALL be the sub-module arb_cmd_fifo (push/pop/full/empty/count); the FSM and stats logic SHALL reside in arb_requester.

Verification
REQ-027 Single read, addr 12'h123: push, ack high 3 cycles after req, rddata 8'h77 -> one transfer, rsp_valid for one cycle with 8'h77, req low the edge after the transfer, then one RELEASE cycle.
REQ-028 Six writes (8'hA0..8'hA5), ack held at 1 -> four transfers, req low for one cycle, re-request, two transfers, FIFO empty.
REQ-029 Push five commands with ack=0 -> cmd_ready=0 after the fourth, fifo_count=4, fifth accepted after the first transfer.
REQ-030 Preemption: ack drops after two of four queued reads and returns 5 cycles later -> req stays 1, remaining two complete in order, preempt_count=1 with STATS_EN defined.
REQ-031 Reset asserted mid-burst with three entries queued -> req, rsp_valid and fifo_count are 0 immediately; after release the FSM stays in IDLE.
REQ-032 Build without ARB_REQUESTER_STATS_EN, rerun REQ-028 -> same bus trace; xfer_count and preempt_count stay 0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared defaults, FSM state encoding and command record for the arbiter requester.
package arb_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 12;
    localparam int unsigned DATA_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    typedef struct packed {
        logic [ADDR_WIDTH_DEF-1:0] addr;
        logic [DATA_WIDTH_DEF-1:0] wrdata;
        logic                      rdWrn;
    } cmd_t;

endpackage

// File: rtl/arb_cmd_fifo.sv
// Command FIFO, 2^DEPTH_LOG2 entries, registered full/empty/count flags.
module arb_cmd_fifo
    import arb_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 2,
    parameter type entry_t = cmd_t
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                push,
    input  entry_t              pushData,
    input  logic                pop,
    output entry_t              head_c,
    output logic                full,
    output logic                empty,
    output logic [DEPTH_LOG2:0] count
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;

    entry_t                mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wrPtr;
    logic [DEPTH_LOG2-1:0] rdPtr;
    logic [DEPTH_LOG2:0]   countNext;
    logic                  doPush;
    logic                  doPop;

    assign doPush = push & ~full;
    assign doPop  = pop & ~empty;
    assign head_c = mem[rdPtr];

    always_comb begin
        countNext = count;
        case ({doPush, doPop})
            2'b10:   countNext = count + CW'(1);
            2'b01:   countNext = count - CW'(1);
            default: countNext = count;
        endcase
    end

    // Pointers wrap naturally at their DEPTH_LOG2 width.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (doPush) wrPtr <= wrPtr + DEPTH_LOG2'(1);
            if (doPop)  rdPtr <= rdPtr + DEPTH_LOG2'(1);
            count <= countNext;
            full  <= (countNext == CW'(DEPTH));
            empty <= (countNext == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= pushData;
    end

endmodule

// File: rtl/arb_requester.sv
// Arbiter client: queues commands and issues them in bounded bursts per grant.
// Define ARB_REQUESTER_STATS_EN to enable the transfer/preemption counters.
module arb_requester
    import arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH      = DATA_WIDTH_DEF,
    parameter int unsigned FIFO_DEPTH_LOG2 = 2,
    parameter int unsigned MAX_BURST       = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [ADDR_WIDTH-1:0]    cmd_addr,
    input  logic [DATA_WIDTH-1:0]    cmd_wrdata,
    input  logic                     cmd_rdWrn,
    output logic                     rsp_valid,
    output logic [DATA_WIDTH-1:0]    rsp_rddata,
    output logic                     req,
    input  logic                     ack,
    output logic [ADDR_WIDTH-1:0]    address,
    output logic [DATA_WIDTH-1:0]    wrdata,
    input  logic [DATA_WIDTH-1:0]    rddata,
    output logic                     rdWrn,
    output logic [FIFO_DEPTH_LOG2:0] fifo_count,
    output logic [15:0]              xfer_count,
    output logic [7:0]               preempt_count
);

    localparam int unsigned CW = FIFO_DEPTH_LOG2 + 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wrdata;
        logic                  rdWrn;
    } entry_t;

    state_t     state;
    state_t     stateNext;
    logic [7:0] burstCnt;
    logic [7:0] burstNext;
    entry_t     pushEntry;
    entry_t     head;
    entry_t     holdEntry;
    entry_t     shown;
    logic       fifoFull;
    logic       fifoEmpty;
    logic       push;
    logic       xfer;
    logic       lastEntry;

    assign pushEntry = '{addr: cmd_addr, wrdata: cmd_wrdata, rdWrn: cmd_rdWrn};
    assign cmd_ready = ~fifoFull;
    assign push      = cmd_valid & ~fifoFull;
    assign xfer      = (state == S_REQ) & ack & ~fifoEmpty;
    assign lastEntry = (fifo_count == CW'(1)) & ~push;

    arb_cmd_fifo #(
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2),
        .entry_t    (entry_t)
    ) uFifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pushData (pushEntry),
        .pop      (xfer),
        .head_c   (head),
        .full     (fifoFull),
        .empty    (fifoEmpty),
        .count    (fifo_count)
    );

    // Bus shows the head entry, or the last transferred entry once drained.
    assign shown   = fifoEmpty ? holdEntry : head;
    assign address = shown.addr;
    assign wrdata  = shown.wrdata;
    assign rdWrn   = shown.rdWrn;

    always_comb begin
        stateNext = state;
        burstNext = burstCnt;
        case (state)
            S_IDLE: begin
                if (!fifoEmpty) begin
                    stateNext = S_REQ;
                    burstNext = '0;
                end
            end
            S_REQ: begin
                if (xfer) begin
                    burstNext = burstCnt + 8'd1;
                    if (lastEntry || (burstCnt + 8'd1 == 8'(MAX_BURST))) stateNext = S_RELEASE;
                end
            end
            S_RELEASE: stateNext = S_IDLE;
            default:   stateNext = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            burstCnt   <= '0;
            req        <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rddata <= '0;
            holdEntry  <= '0;
        end else begin
            state     <= stateNext;
            burstCnt  <= burstNext;
            req       <= (stateNext == S_REQ);
            rsp_valid <= xfer & head.rdWrn;
            if (xfer) begin
                holdEntry <= head;
                if (head.rdWrn) rsp_rddata <= rddata;
            end
        end
    end

`ifdef ARB_REQUESTER_STATS_EN
    logic        ackPrev;
    logic [15:0] xferCnt;
    logic [7:0]  preemptCnt;

    // Preemption is a grant withdrawn while work is still queued.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ackPrev    <= 1'b0;
            xferCnt    <= '0;
            preemptCnt <= '0;
        end else begin
            ackPrev <= ack;
            if (xfer && (xferCnt != 16'hFFFF)) xferCnt <= xferCnt + 16'd1;
            if (ackPrev && !ack && (state == S_REQ) && !fifoEmpty && (preemptCnt != 8'hFF))
                preemptCnt <= preemptCnt + 8'd1;
        end
    end

    assign xfer_count    = xferCnt;
    assign preempt_count = preemptCnt;
`else
    assign xfer_count    = '0;
    assign preempt_count = '0;
`endif

endmodule

// File: tb/tb_arb_requester.sv
// Self-checking bench for arb_requester: queue-based reference model plus directed scenarios.
module tb_arb_requester;

    localparam int unsigned AW    = 12;
    localparam int unsigned DW    = 8;
    localparam int unsigned FL2   = 2;
    localparam int unsigned MB    = 4;
    localparam int unsigned DEPTH = 4;

`ifdef ARB_REQUESTER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wrdata = '0;
    logic          cmd_rdWrn = 1'b0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rddata;
    logic          req;
    logic          ack = 1'b0;
    logic [AW-1:0] address;
    logic [DW-1:0] wrdata;
    logic [DW-1:0] rddata;
    logic          rdWrn;
    logic [FL2:0]  fifo_count;
    logic [15:0]   xfer_count;
    logic [7:0]    preempt_count;

    int tests = 0;
    int fails = 0;
    bit checkEn = 1'b0;

    always #5 clk = ~clk;

    // Slave returns a value derived from the address it is shown.
    assign rddata = address[7:0] ^ 8'h54;

    arb_requester #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH_LOG2(FL2), .MAX_BURST(MB)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_wrdata(cmd_wrdata), .cmd_rdWrn(cmd_rdWrn),
        .rsp_valid(rsp_valid), .rsp_rddata(rsp_rddata),
        .req(req), .ack(ack), .address(address), .wrdata(wrdata),
        .rddata(rddata), .rdWrn(rdWrn),
        .fifo_count(fifo_count), .xfer_count(xfer_count), .preempt_count(preempt_count)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeoutFail(input string nm);
        tests++;
        fails++;
        $display("FAIL %s: timed out at %0t", nm, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          rd;
    } ent_t;

    ent_t          q[$];
    ent_t          mHold = '{addr: '0, data: '0, rd: 1'b0};
    bit            mReq = 1'b0;
    bit            mRel = 1'b0;
    bit            mRspV = 1'b0;
    bit            mAckPrev = 1'b0;
    logic [DW-1:0] mRspD = '0;
    int            mBurst = 0;
    int            mXfer = 0;
    int            mPre = 0;

    always @(posedge clk or negedge reset) begin
        int   sz;
        bit   doPush;
        bit   doXfer;
        ent_t e;
        if (!reset) begin
            q.delete();
            mHold    = '{addr: '0, data: '0, rd: 1'b0};
            mReq     = 1'b0;
            mRel     = 1'b0;
            mRspV    = 1'b0;
            mAckPrev = 1'b0;
            mRspD    = '0;
            mBurst   = 0;
            mXfer    = 0;
            mPre     = 0;
        end else begin
            sz     = q.size();
            doPush = cmd_valid && (sz < DEPTH);
            doXfer = mReq && ack && (sz > 0);
            if (mAckPrev && !ack && mReq && sz > 0 && mPre < 255) mPre++;
            mAckPrev = ack;
            mRspV = 1'b0;
            if (mRel) begin
                mRel = 1'b0;
            end else if (mReq) begin
                if (doXfer) begin
                    e = q.pop_front();
                    mHold = e;
                    mBurst++;
                    if (mXfer < 65535) mXfer++;
                    if (e.rd) begin
                        mRspV = 1'b1;
                        mRspD = e.addr[7:0] ^ 8'h54;
                    end
                    if ((sz == 1 && !doPush) || mBurst == MB) begin
                        mReq = 1'b0;
                        mRel = 1'b1;
                    end
                end
            end else if (sz > 0) begin
                mReq   = 1'b1;
                mBurst = 0;
            end
            if (doPush) q.push_back('{addr: cmd_addr, data: cmd_wrdata, rd: cmd_rdWrn});
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        ent_t s;
        if (checkEn) begin
            s = (q.size() > 0) ? q[0] : mHold;
            check("req", 32'(req), 32'(mReq));
            check("cmd_ready", 32'(cmd_ready), 32'(q.size() < DEPTH));
            check("fifo_count", 32'(fifo_count), 32'(q.size()));
            check("rsp_valid", 32'(rsp_valid), 32'(mRspV));
            check("rsp_rddata", 32'(rsp_rddata), 32'(mRspD));
            check("address", 32'(address), 32'(s.addr));
            check("wrdata", 32'(wrdata), 32'(s.data));
            check("rdWrn", 32'(rdWrn), 32'(s.rd));
            check("xfer_count", 32'(xfer_count), STATS ? 32'(mXfer) : 32'd0);
            check("preempt_count", 32'(preempt_count), STATS ? 32'(mPre) : 32'd0);
        end
    end

    // ---------------- observation helpers ----------------
    logic [DW-1:0] rspLog[$];
    int            bursts[$];
    int            curBurst = 0;
    bit            prevReq = 1'b0;

    always @(posedge clk) begin
        if (reset && req && ack && fifo_count != 0) curBurst++;
    end

    always @(negedge clk) begin
        if (reset && rsp_valid === 1'b1) rspLog.push_back(rsp_rddata);
        if (prevReq && !req) begin
            bursts.push_back(curBurst);
            curBurst = 0;
        end
        prevReq = req;
    end

    // Call at posedge+1; leaves cmd_valid asserted at posedge+1 after acceptance.
    task automatic pushCmd(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic rd);
        int n;
        n = 0;
        cmd_valid  = 1'b1;
        cmd_addr   = a;
        cmd_wrdata = d;
        cmd_rdWrn  = rd;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) timeoutFail("push_accept");
        @(posedge clk);
        #1;
    endtask

    task automatic waitReqHigh();
        int n;
        n = 0;
        @(negedge clk);
        while (req !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (req !== 1'b1) timeoutFail("wait_req");
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        @(negedge clk);
        while ((fifo_count != 0 || req !== 1'b0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (fifo_count != 0 || req !== 1'b0) timeoutFail("drain");
        repeat (3) @(negedge clk);
    endtask

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        #2;
        check("rst_req", 32'(req), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_fifo_count", 32'(fifo_count), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_address", 32'(address), 32'd0);
        check("rst_xfer_count", 32'(xfer_count), 32'd0);
        checkEn = 1'b1;
        #21 reset = 1'b1;
        repeat (2) @(negedge clk);

        // Single read at 12'h123, ack 3 cycles after req
        rspLog.delete();
        align();
        pushCmd(12'h123, 8'h00, 1'b1);
        cmd_valid = 1'b0;
        waitReqHigh();
        repeat (3) @(posedge clk);
        #1 ack = 1'b1;
        waitDrain();
        ack = 1'b0;
        check("s1_rsp_count", 32'(rspLog.size()), 32'd1);
        check("s1_rsp_data", (rspLog.size() > 0) ? 32'(rspLog[0]) : 32'hDEAD, 32'h77);

        // Six writes, ack held high: bursts of 4 then 2
        bursts.delete();
        curBurst = 0;
        align();
        ack = 1'b1;
        for (int i = 0; i < 6; i++) pushCmd(12'h300 + AW'(i), 8'hA0 + DW'(i), 1'b0);
        cmd_valid = 1'b0;
        waitDrain();
        ack = 1'b0;
        check("s2_burst_n", 32'(bursts.size()), 32'd2);
        check("s2_burst0", (bursts.size() > 0) ? 32'(bursts[0]) : 32'hDEAD, 32'd4);
        check("s2_burst1", (bursts.size() > 1) ? 32'(bursts[1]) : 32'hDEAD, 32'd2);
        check("s2_fifo_empty", 32'(fifo_count), 32'd0);
        check("s2_last_wrdata", 32'(wrdata), 32'hA5);

        // Five pushes with ack low: full after four
        align();
        fork
            begin
                for (int i = 0; i < 5; i++) pushCmd(12'h400 + AW'(i), 8'h10 + DW'(i), 1'b0);
                cmd_valid = 1'b0;
            end
            begin
                int n;
                n = 0;
                @(negedge clk);
                while (fifo_count != 4 && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                check("s3_full_count", 32'(fifo_count), 32'd4);
                check("s3_ready_low", 32'(cmd_ready), 32'd0);
                repeat (3) @(negedge clk);
                check("s3_still_full", 32'(fifo_count), 32'd4);
                @(posedge clk);
                #1 ack = 1'b1;
            end
        join
        waitDrain();
        ack = 1'b0;
        check("s3_fifo_empty", 32'(fifo_count), 32'd0);
        check("s3_last_addr", 32'(address), 32'h404);

        // Preemption after two of four reads
        rspLog.delete();
        align();
        for (int i = 0; i < 4; i++) pushCmd(12'h200 + AW'(i), 8'h00, 1'b1);
        cmd_valid = 1'b0;
        ack = 1'b1;
        repeat (2) @(posedge clk);
        #1 ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("s4_req_held", 32'(req), 32'd1);
        end
        check("s4_pending", 32'(fifo_count), 32'd2);
        @(posedge clk);
        #1 ack = 1'b1;
        waitDrain();
        ack = 1'b0;
        check("s4_rsp_count", 32'(rspLog.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            check("s4_rsp_order", (rspLog.size() > i) ? 32'(rspLog[i]) : 32'hDEAD, 32'h54 + 32'(i));
        check("s4_preempt", 32'(preempt_count), STATS ? 32'd1 : 32'd0);
        check("s4_xfer_total", 32'(xfer_count), STATS ? 32'd16 : 32'd0);

        // Reset mid-burst with three entries queued
        align();
        for (int i = 0; i < 4; i++) pushCmd(12'h500 + AW'(i), 8'h00, 1'b1);
        cmd_valid = 1'b0;
        ack = 1'b1;
        @(posedge clk);
        #1 ack = 1'b0;
        #2;
        check("s5_pre_rsp_valid", 32'(rsp_valid), 32'd1);
        check("s5_pre_count", 32'(fifo_count), 32'd3);
        reset = 1'b0;
        #1;
        check("s5_req", 32'(req), 32'd0);
        check("s5_rsp_valid", 32'(rsp_valid), 32'd0);
        check("s5_fifo_count", 32'(fifo_count), 32'd0);
        check("s5_address", 32'(address), 32'd0);
        check("s5_xfer_count", 32'(xfer_count), 32'd0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("s5_idle_after", 32'(req), 32'd0);
        end

        checkEn = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
